// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mul/div sequencer.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    // Bits needed to hold every value 0..max_val of the latency down-counter.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline side is the master, hazard_ctrl is the slave.
interface hazard_ctrl_if;

    logic       MemRead_EX;
    logic [4:0] WrAddr_EX;
    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       UseRs_ID;
    logic       UseRt_ID;
    logic       MulDiv_ID;
    logic       HiLoRd_ID;
    logic       MulDiv_start_EX;
    logic       MulDiv_isdiv_EX;
    logic       Redirect_EX;
    logic       Stall_PC;
    logic       Stall_IFID;
    logic       Bubble_IDEX;
    logic       Flush_IFID;
    logic       MulDiv_busy;
    logic       HiLo_we;

    modport master (
        output MemRead_EX, WrAddr_EX, Rs_ID, Rt_ID, UseRs_ID, UseRt_ID,
               MulDiv_ID, HiLoRd_ID, MulDiv_start_EX, MulDiv_isdiv_EX, Redirect_EX,
        input  Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID, MulDiv_busy, HiLo_we
    );

    modport slave (
        input  MemRead_EX, WrAddr_EX, Rs_ID, Rt_ID, UseRs_ID, UseRt_ID,
               MulDiv_ID, HiLoRd_ID, MulDiv_start_EX, MulDiv_isdiv_EX, Redirect_EX,
        output Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID, MulDiv_busy, HiLo_we
    );

endinterface

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Multi-cycle mul/div sequencer: occupancy tracking and the one-cycle HI/LO write strobe.
//   state | meaning
//   IDLE  | unit free, waiting for a launch from EX
//   RUN   | op in flight, r_cnt = cycles left before the HI/LO write
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_isdiv,
    output logic o_busy,
    output logic o_hilo_we
);

    localparam int CW = cnt_width(DIV_LAT);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

    md_state_e     r_state;
    md_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_load;
    logic          w_hilo_we;

    assign w_load = i_isdiv ? DIV_LD : MUL_LD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hilo_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_cnt_nxt   = w_load;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_hilo_we = 1'b1;
                    // A launch in the write cycle chains straight into the next op.
                    if (i_start) begin
                        w_cnt_nxt = w_load;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy    = (r_state == RUN);
    assign o_hilo_we = w_hilo_we;

    a_no_launch_mid_op: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == RUN) && (r_cnt != '0) && i_start))
        else $error("muldiv_seq: launch while an operation is still counting");

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / HI-LO stall and redirect flush control for the 5-stage core.
// Define HAZARD_MULDIV_EN to include the multi-cycle mul/div sequencer and its stall term.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    logic w_lu;
    logic w_md;
    logic w_stall;
    logic w_busy;
    logic w_hilo_we;

    assign w_lu = hz.MemRead_EX && (hz.WrAddr_EX != 5'd0) &&
                  ((hz.UseRs_ID && (hz.Rs_ID == hz.WrAddr_EX)) ||
                   (hz.UseRt_ID && (hz.Rt_ID == hz.WrAddr_EX)));

`ifdef HAZARD_MULDIV_EN
    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_muldiv_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (hz.MulDiv_start_EX),
        .i_isdiv   (hz.MulDiv_isdiv_EX),
        .o_busy    (w_busy),
        .o_hilo_we (w_hilo_we)
    );

    assign w_md = w_busy && (hz.MulDiv_ID || hz.HiLoRd_ID);
`else
    // Single-cycle HI/LO datapath: mul/div never occupies the pipeline.
    logic w_unused_md;
    assign w_unused_md = hz.MulDiv_ID ^ hz.HiLoRd_ID ^ hz.MulDiv_start_EX ^
                         hz.MulDiv_isdiv_EX ^ clk ^ rst_n ^ (MUL_LAT > DIV_LAT);
    assign w_busy    = 1'b0;
    assign w_hilo_we = 1'b0;
    assign w_md      = 1'b0;
`endif

    // A redirect makes the ID instruction wrong-path, so it is squashed instead of held.
    assign w_stall = (w_lu || w_md) && !hz.Redirect_EX;

    assign hz.Stall_PC    = w_stall;
    assign hz.Stall_IFID  = w_stall;
    assign hz.Bubble_IDEX = w_stall || hz.Redirect_EX;
    assign hz.Flush_IFID  = hz.Redirect_EX;
    assign hz.MulDiv_busy = w_busy;
    assign hz.HiLo_we     = w_hilo_we;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core, complementing the bypass unit. Bypassing resolves RAW dependences whose result already exists in EX or MEM. This block handles the cases bypassing cannot cover:
- load-use dependences;
- HI/LO reads while a multiply/divide is still in flight;
- wrong-path instructions after a taken branch or jump resolved in EX.

It owns the multi-cycle mul/div sequencer and drives the stall, bubble and flush controls of the PC, IF/ID and ID/EX registers.

## Interface
Parameters:
- MUL_LAT, default 4: cycles a mult/multu occupies the mul/div unit (≥1).
- DIV_LAT, default 32: cycles a div/divu occupies the mul/div unit (≥1, ≥ MUL_LAT).

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead_EX  in  1  instruction in EX is a load.
- WrAddr_EX  in  5  destination register of the EX instruction.
- Rs_ID, Rt_ID  in  5  source register numbers in ID.
- UseRs_ID, UseRt_ID  in  1  ID instruction actually reads Rs / Rt.
- MulDiv_ID  in  1  ID holds mult/multu/div/divu.
- HiLoRd_ID  in  1  ID holds mfhi/mflo.
- MulDiv_start_EX  in  1  mul/div instruction is in EX this cycle (launch).
- MulDiv_isdiv_EX  in  1  launched op is div/divu (selects DIV_LAT).
- Redirect_EX  in  1  taken branch/jump resolved in EX.
- Stall_PC  out  1  hold PC.
- Stall_IFID  out  1  hold IF/ID register.
- Bubble_IDEX  out  1  load NOP into ID/EX.
- Flush_IFID  out  1  clear IF/ID to NOP.
- MulDiv_busy  out  1  sequencer occupied.
- HiLo_we  out  1  one-cycle pulse: write mul/div result to HI/LO.

## Operation
- Load-use hazard: `lu = MemRead_EX && WrAddr_EX!=0 && ((UseRs_ID && Rs_ID==WrAddr_EX) || (UseRt_ID && Rt_ID==WrAddr_EX))`.
- Structural/HI-LO hazard: `md = MulDiv_busy && (MulDiv_ID || HiLoRd_ID)`.
- `stall = (lu || md) && !Redirect_EX`, which gives:
  - Stall_PC = stall;
  - Stall_IFID = stall;
  - Bubble_IDEX = stall || Redirect_EX;
  - Flush_IFID = Redirect_EX.
- Redirect has priority over stall: the ID instruction is wrong-path, so it is discarded rather than held.
- Sequencer FSM with states IDLE, RUN, and a down-counter `cnt` of width clog2(DIV_LAT+1):
  - IDLE, MulDiv_start_EX=1: load `cnt = (isdiv ? DIV_LAT : MUL_LAT) - 1`, go to RUN.
  - RUN, cnt≠0: decrement.
  - RUN, cnt==0: assert HiLo_we, go to IDLE. If MulDiv_start_EX=1 in that same cycle, reload and stay in RUN (back-to-back).
  - MulDiv_start_EX while RUN and cnt≠0 is a protocol violation. The ID stall prevents it; it is ignored and flagged by an assertion.
- MulDiv_busy = (state==RUN).
- Divide-by-zero consumes the full DIV_LAT; it has no special timing.

## Timing
- Hazard outputs are combinational from inputs and state. There is no added latency: a load-use stall lasts exactly one cycle, because the load advances to MEM and the bypass unit covers it afterwards.
- Launch in cycle T:
  - MulDiv_busy is high T+1 … T+LAT;
  - HiLo_we pulses at T+LAT;
  - a stalled mfhi/mflo leaves ID at T+LAT+1 and reads the written HI/LO.
- Reset values: state IDLE, cnt 0, MulDiv_busy 0, HiLo_we 0. Stall and flush outputs are 0 whenever their request inputs are 0.
- rst_n asserted mid-operation aborts the sequencer immediately (asynchronously). No HiLo_we is issued.
- Simultaneous load-use and md: a single merged stall. It persists until both conditions clear.

## Configuration
- HAZARD_MULDIV_EN defined: sequencer, MUL_LAT/DIV_LAT and md stall behave as above.
- HAZARD_MULDIV_EN undefined: sequencer and md term are removed; MulDiv_busy and HiLo_we are tied 0; mul/div inputs are ignored. This is the configuration for cores with a single-cycle HI/LO datapath.

## Structure
- hazard_pkg:
  - state typedef (IDLE, RUN);
  - default latency constants;
  - counter-width function.
- One sub-module, muldiv_seq, containing the FSM, counter and HiLo_we generation.
- The top level holds the combinational hazard/flush logic.

## Test plan
- lw $t0 in EX (WrAddr_EX=8), ID add uses Rs=8 → stall=1, Bubble_IDEX=1 for exactly one cycle. With WrAddr_EX=0 → no stall.
- Launch mult at T with MUL_LAT=4; mflo in ID at T+1 → Stall_PC held T+1…T+4, HiLo_we at T+4, mflo proceeds T+5.
- Launch div (DIV_LAT=32), second mult in ID → stalled 32 cycles; back-to-back launch at HiLo_we cycle keeps busy high continuously.
- Redirect_EX=1 coincident with load-use hazard → Flush_IFID=1, Bubble_IDEX=1, Stall_PC=0.
- rst_n low at count 10 of a div → busy=0 immediately, no HiLo_we; a new mult after release completes in MUL_LAT.
- Build without HAZARD_MULDIV_EN: HiLoRd_ID=1, MulDiv_start_EX=1 → no stall, busy=0.
